// File: rtl/stream_gen_t2_pkg.sv
// Shared constants and FSM encoding for the stream generator
// and the stream checker that consumes its output.
package stream_test_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/stream_gen_t2_if.sv
// Burst control and half-word stream bundle.
// master: generator side (drives data/wren/busy/done/words_sent).
// slave: controller/sink side (drives start/len/seed/ready/err).
import stream_test_pkg::*;

interface stream_gen_t2_if #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic                start;
  logic [LEN_W-1:0]    burst_len;
  logic [2*DATA_W-1:0] seed;
  logic                ready;
  logic                inject_err;
  logic [DATA_W-1:0]   data;
  logic                wren;
  logic                busy;
  logic                done;
  logic [LEN_W-1:0]    words_sent;

  modport master (
    input  start, burst_len, seed,
    input  ready, inject_err,
    output data, wren, busy, done,
    output words_sent
  );

  modport slave (
    output start, burst_len, seed,
    output ready, inject_err,
    input  data, wren, busy, done,
    input  words_sent
  );

endinterface

// File: rtl/stream_gen_t2.sv
// Test-pattern burst generator: emits incrementing 32-bit
// words as hi/lo half-words. Ports: clk, rst, bus (master).
import stream_test_pkg::*;

module stream_gen_t2 #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  stream_gen_t2_if.master bus
);

  localparam int WORD_W = 2 * DATA_W;

  state_e              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   word_d;
  logic [DATA_W-1:0]   data_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    sent_q;
  logic [LEN_W-1:0]    sent_d;
  logic                busy_q;
  logic                done_q;
  logic                pend_q;
  logic                bump2;

  // A pending or same-cycle error request makes the
  // next advance skip one value.
  always_comb begin
    bump2  = pend_q | bus.inject_err;
    word_d = word_q + (bump2 ? WORD_W'(2) : WORD_W'(1));
    sent_d = sent_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.inject_err && state_q != ST_IDLE)
        pend_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_q  <= bus.burst_len;
            sent_q <= '0;
            busy_q <= 1'b1;
            if (bus.burst_len != '0) begin
              word_q  <= bus.seed;
              data_q  <= bus.seed[WORD_W-1:DATA_W];
              state_q <= ST_HI;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_HI: begin
          if (bus.ready) begin
            data_q  <= word_q[DATA_W-1:0];
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.ready) begin
            sent_q <= sent_d;
            if (sent_d == len_q) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              // data_q preloads the next high half so it
              // is already stable on the first HI cycle.
              word_q  <= word_d;
              data_q  <= word_d[WORD_W-1:DATA_W];
              pend_q  <= 1'b0;
              state_q <= ST_HI;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          pend_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // wren follows ready in the same cycle so a sink can
  // stall any half without losing it.
  assign bus.wren = bus.ready &
                    (state_q == ST_HI || state_q == ST_LO);
  assign bus.data       = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.words_sent = sent_q;

endmodule
